// File: rtl/mem_stall_ctrl.sv
// Pipeline stall controller: per-channel outstanding-request counters drive the
// global move enable, with optional response bypass, drain mode and statistics.
module mem_stall_ctrl #(
  parameter int                   NUM_PORTS        = 2,
  parameter int                   MAX_OUTSTANDING  = 1,
  parameter logic [NUM_PORTS-1:0] INIT_OUTSTANDING = NUM_PORTS'(1),
  parameter bit                   BYPASS           = 1'b0,
  parameter int                   STALL_CNT_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS-1:0]   resp,
  input  logic                   flush,
  input  logic                   stat_clr,
  output logic                   move,
  output logic [NUM_PORTS-1:0]   req_ready,
  output logic                   outstanding_any,
  output logic [NUM_PORTS-1:0]   err_underflow,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int            CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [NUM_PORTS-1:0][CW-1:0]  r_cnt;
  logic [NUM_PORTS-1:0][CW-1:0]  w_cnt_nxt;
  logic [NUM_PORTS-1:0]          w_req_ok;
  logic [NUM_PORTS-1:0]          w_acc;
  logic [NUM_PORTS-1:0]          w_resp_eff;
  logic [NUM_PORTS-1:0]          w_underflow;
  logic [NUM_PORTS-1:0]          w_idle_nxt;
  logic [NUM_PORTS-1:0]          w_idle_byp;
  logic [NUM_PORTS-1:0]          r_err;
  logic [STALL_CNT_W-1:0]        r_stall;
  logic                          w_move_core;

  // req_ready only looks at registered counters, so resp never reaches it combinationally
  always_comb begin
    w_req_ok    = '0;
    w_acc       = '0;
    w_resp_eff  = '0;
    w_underflow = '0;
    w_idle_nxt  = '0;
    w_idle_byp  = '0;
    w_cnt_nxt   = r_cnt;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_req_ok[i]    = (r_cnt[i] < MAX_CNT) && (r_state != ST_DRAIN);
      w_acc[i]       = req[i] & w_req_ok[i];
      w_resp_eff[i]  = resp[i] & ((r_cnt[i] != '0) | w_acc[i]);
      w_underflow[i] = resp[i] & (r_cnt[i] == '0) & ~w_acc[i];
      case ({w_acc[i], w_resp_eff[i]})
        2'b10:   w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        2'b01:   w_cnt_nxt[i] = r_cnt[i] - CW'(1);
        default: w_cnt_nxt[i] = r_cnt[i];
      endcase
      w_idle_nxt[i] = (w_cnt_nxt[i] == '0);
      // Bypass view: this cycle's response retires the last request, new requests ignored
      w_idle_byp[i] = (r_cnt[i] == '0) | (resp[i] & (r_cnt[i] == CW'(1)));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (|w_acc)      w_state_nxt = ST_WAIT;
      ST_WAIT:  if (&w_idle_nxt) w_state_nxt = ST_RUN;
      ST_DRAIN: if (&w_idle_nxt) w_state_nxt = ST_RUN;
      default:                   w_state_nxt = ST_RUN;
    endcase
    if (flush) w_state_nxt = ST_DRAIN;

    if (BYPASS) w_move_core = (&w_idle_byp) && (r_state != ST_DRAIN) && !flush;
    else        w_move_core = (r_state == ST_RUN) && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= (INIT_OUTSTANDING != '0) ? ST_WAIT : ST_RUN;
      for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= CW'(INIT_OUTSTANDING[i]);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Statistics: clear wins over both the sticky error set and the stall increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err   <= '0;
      r_stall <= '0;
    end else if (stat_clr) begin
      r_err   <= '0;
      r_stall <= '0;
    end else begin
      r_err <= r_err | w_underflow;
      if (!w_move_core && (r_stall != '1)) r_stall <= r_stall + STALL_CNT_W'(1);
    end
  end

  assign move            = ~rst_n | w_move_core;
  assign req_ready       = rst_n ? w_req_ok : '0;
  assign outstanding_any = |r_cnt;
  assign err_underflow   = r_err;
  assign stall_cycles    = r_stall;

endmodule
